// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the
// multi-read-port register file.
package regfile_pkg;

    localparam int DATA_W_D = 16;
    localparam int ADDR_W_D = 4;
    localparam int NUM_RD_D = 2;

    typedef logic [0:0] clr_st_t;

    localparam clr_st_t ST_IDLE  = 1'b0;
    localparam clr_st_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks every register index once,
// one per cycle, while holding busy.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clrReq,
    output logic              busy,
    output logic              clrEn,
    output logic [ADDR_W-1:0] clrAddr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_st_t           st;
    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= ST_IDLE;
            ptr <= '0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (clrReq) begin
                        st  <= ST_CLEAR;
                        ptr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr == LAST) begin
                        st  <= ST_IDLE;
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    st  <= ST_IDLE;
                    ptr <= '0;
                end
            endcase
        end
    end

    assign busy    = (st == ST_CLEAR);
    assign clrEn   = (st == ST_CLEAR);
    assign clrAddr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: N combinational read ports,
// one write port, optional r0-zero, bypass and soft clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int ADDR_W  = ADDR_W_D,
    parameter int NUM_RD  = NUM_RD_D,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        selRd,
    input  logic [DATA_W-1:0]        rd,
    input  logic [NUM_RD*ADDR_W-1:0] selR,
    output logic [NUM_RD*DATA_W-1:0] rOut,
    input  logic                     clrReq,
    output logic                     busy,
    output logic                     wrDrop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              r0_hit;
    logic              wr_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .clrReq  (clrReq),
        .busy    (busy),
        .clrEn   (clr_en),
        .clrAddr (clr_addr)
    );

    assign r0_hit = (ZERO_R0 != 0) && (selRd == '0);
    assign wr_ok  = wen && !busy && !r0_hit;

    // Clear engine owns the write port while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[selRd] <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrDrop <= 1'b0;
        end else begin
            wrDrop <= wen && busy;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] s;
        logic              z;
        logic              byp;
        logic [DATA_W-1:0] q;

        assign s   = selR[k*ADDR_W +: ADDR_W];
        assign z   = (ZERO_R0 != 0) && (s == '0);
        assign byp = (BYPASS != 0) && wr_ok && (selRd == s);

        always_comb begin
            q = mem[s];
            unique case (1'b1)
                z:       q = '0;
                byp:     q = rd;
                default: q = mem[s];
            endcase
        end

        assign rOut[k*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp with a
// countdown-style reference model of storage and soft clear.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        a_wen, a_clr, a_busy, a_drop;
    logic [3:0]  a_selRd;
    logic [15:0] a_rd;
    logic [7:0]  a_selR;
    logic [31:0] a_rOut;

    logic         b_wen, b_clr, b_busy, b_drop;
    logic [4:0]   b_selRd;
    logic [31:0]  b_rd;
    logic [19:0]  b_selR;
    logic [127:0] b_rOut;

    regfile_mp #(
        .DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_R0(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .rst(rst), .wen(a_wen), .selRd(a_selRd), .rd(a_rd),
        .selR(a_selR), .rOut(a_rOut), .clrReq(a_clr), .busy(a_busy),
        .wrDrop(a_drop)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_R0(1), .BYPASS(0)
    ) u_b (
        .clk(clk), .rst(rst), .wen(b_wen), .selRd(b_selRd), .rd(b_rd),
        .selR(b_selR), .rOut(b_rOut), .clrReq(b_clr), .busy(b_busy),
        .wrDrop(b_drop)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] ma [16];
    logic [31:0] mb [32];
    int          a_left, a_idx, b_left, b_idx;
    logic        a_xdrop, b_xdrop;

    task automatic reset_model();
        for (int i = 0; i < 16; i++) ma[i] = '0;
        for (int i = 0; i < 32; i++) mb[i] = '0;
        a_left = 0; a_idx = 0; a_xdrop = 1'b0;
        b_left = 0; b_idx = 0; b_xdrop = 1'b0;
    endtask

    // Model: a clear is "remaining cycles" plus a next index.
    always @(posedge clk) begin
        if (rst) begin
            if (a_left > 0) begin
                ma[a_idx] = '0;
                a_idx++;
                a_left--;
                a_xdrop = a_wen;
            end else begin
                a_xdrop = 1'b0;
                if (a_wen && a_selRd != 0) ma[a_selRd] = a_rd;
                if (a_clr) begin
                    a_left = 16;
                    a_idx  = 0;
                end
            end
            if (b_left > 0) begin
                mb[b_idx] = '0;
                b_idx++;
                b_left--;
                b_xdrop = b_wen;
            end else begin
                b_xdrop = 1'b0;
                if (b_wen && b_selRd != 0) mb[b_selRd] = b_rd;
                if (b_clr) begin
                    b_left = 32;
                    b_idx  = 0;
                end
            end
        end
    end

    function automatic logic [15:0] expa(input logic [3:0] s);
        if (s == 4'd0) return 16'h0;
        if (a_wen && a_left == 0 && a_selRd == s) return a_rd;
        return ma[s];
    endfunction

    function automatic logic [31:0] expb(input logic [4:0] s);
        if (s == 5'd0) return 32'h0;
        return mb[s];
    endfunction

    task automatic fill_a(input logic [15:0] base);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            a_wen   = 1'b1;
            a_selRd = 4'(i);
            a_rd    = base + 16'(i);
        end
        @(negedge clk);
        a_wen = 1'b0;
    endtask

    task automatic drain();
        a_wen = 1'b0; a_clr = 1'b0;
        b_wen = 1'b0; b_clr = 1'b0;
        for (int n = 0; n < 80 && (a_busy || b_busy || a_left > 0 || b_left > 0); n++)
            @(negedge clk);
        #1;
        total++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout busy_a=%b busy_b=%b want 0", a_busy, b_busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            a_selR = {4'(k), 4'(k)};
            #1;
            for (int p = 0; p < 2; p++) begin
                total++;
                if (a_rOut[p*16 +: 16] !== 16'h0) begin
                    bad++;
                    $display("FAIL por_read r%0d p%0d got=%h want=0", k, p, a_rOut[p*16 +: 16]);
                end
            end
        end
        b_selR = {5'd31, 5'd7, 5'd1, 5'd0};
        #1;
        for (int p = 0; p < 4; p++) begin
            total++;
            if (b_rOut[p*32 +: 32] !== 32'h0) begin
                bad++;
                $display("FAIL por_read_b p%0d got=%h want=0", p, b_rOut[p*32 +: 32]);
            end
        end
        total++;
        if (a_busy !== 1'b0 || a_drop !== 1'b0 || b_busy !== 1'b0 || b_drop !== 1'b0) begin
            bad++;
            $display("FAIL por_status got=%b%b%b%b want=0000", a_busy, a_drop, b_busy, b_drop);
        end
        @(negedge clk);
        rst = 1'b1;
        fill_a(16'h0000);
        a_selR = {4'd7, 4'd15};
        #1;
        total++;
        if (a_rOut !== {expa(4'd7), expa(4'd15)}) begin
            bad++;
            $display("FAIL prefill got=%h want=%h", a_rOut, {expa(4'd7), expa(4'd15)});
        end
        #1;
        rst = 1'b0;
        reset_model();
        #1;
        for (int k = 0; k < 16; k++) begin
            a_selR = {4'(k), 4'(k)};
            #1;
            total++;
            if (a_rOut !== 32'h0) begin
                bad++;
                $display("FAIL async_reset r%0d got=%h want=0", k, a_rOut);
            end
        end
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", a_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (a_busy !== (a_left > 0)) begin
            bad++;
            $display("FAIL midclear_busy got=%b want=%b", a_busy, a_left > 0);
        end
        #1;
        rst = 1'b0;
        reset_model();
        #1;
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL midclear_reset got=%b want=0", a_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL no_resume got=%b want=0", a_busy);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_wen = 1'b1; a_selRd = 4'd5; a_rd = 16'hBEEF;
        a_selR = {4'd5, 4'd5};
        #1;
        total++;
        if (a_rOut !== {16'hBEEF, 16'hBEEF}) begin
            bad++;
            $display("FAIL bypass_same_cycle got=%h want=beefbeef", a_rOut);
        end
        @(negedge clk);
        a_wen = 1'b0;
        #1;
        total++;
        if (a_rOut[15:0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL stored_read got=%h want=beef", a_rOut[15:0]);
        end
        b_wen = 1'b1; b_selRd = 5'd5; b_rd = 32'hDEADBEEF;
        b_selR = {4{5'd5}};
        #1;
        for (int p = 0; p < 4; p++) begin
            total++;
            if (b_rOut[p*32 +: 32] !== expb(5'd5)) begin
                bad++;
                $display("FAIL nobypass_same p%0d got=%h want=%h", p, b_rOut[p*32 +: 32], expb(5'd5));
            end
        end
        @(negedge clk);
        b_wen = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            total++;
            if (b_rOut[p*32 +: 32] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL nobypass_next p%0d got=%h want=deadbeef", p, b_rOut[p*32 +: 32]);
            end
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        a_wen = 1'b1; a_selRd = 4'd0; a_rd = 16'h1234;
        a_selR = 8'h00;
        #1;
        total++;
        if (a_rOut !== 32'h0) begin
            bad++;
            $display("FAIL r0_bypass got=%h want=0", a_rOut);
        end
        @(negedge clk);
        a_wen = 1'b0;
        #1;
        total++;
        if (a_rOut !== 32'h0 || a_drop !== 1'b0) begin
            bad++;
            $display("FAIL r0_store got=%h drop=%b want=0 0", a_rOut, a_drop);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            a_wen   = 1'($urandom);
            a_selRd = 4'($urandom);
            a_rd    = 16'($urandom);
            a_selR  = 8'($urandom);
            a_clr   = ($urandom_range(0, 40) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                total++;
                if (a_rOut[p*16 +: 16] !== expa(a_selR[p*4 +: 4])) begin
                    bad++;
                    $display("FAIL rand_a n%0d p%0d got=%h want=%h", n, p,
                             a_rOut[p*16 +: 16], expa(a_selR[p*4 +: 4]));
                end
            end
            total++;
            if (a_busy !== (a_left > 0) || a_drop !== a_xdrop) begin
                bad++;
                $display("FAIL rand_a_status n%0d got=%b%b want=%b%b", n,
                         a_busy, a_drop, a_left > 0, a_xdrop);
            end
        end
        drain();
    endtask

    task automatic test_soft_clear();
        int n;
        fill_a(16'hA000);
        a_clr = 1'b1;
        #1;
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_pre_busy got=%b want=0", a_busy);
        end
        @(negedge clk);
        a_clr = 1'b0;
        n = 0;
        while (a_busy === 1'b1 && n < 40) begin
            a_selR = {4'(n - 1), 4'(n)};
            #1;
            total++;
            if (a_rOut[15:0] !== ((n == 0) ? 16'h0 : 16'hA000 + 16'(n))) begin
                bad++;
                $display("FAIL clr_pending c%0d got=%h want=%h", n, a_rOut[15:0],
                         (n == 0) ? 16'h0 : 16'hA000 + 16'(n));
            end
            if (n > 0) begin
                total++;
                if (a_rOut[31:16] !== 16'h0) begin
                    bad++;
                    $display("FAIL clr_done c%0d got=%h want=0", n, a_rOut[31:16]);
                end
            end
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL clr_len got=%0d want=16", n);
        end
        for (int k = 0; k < 16; k++) begin
            a_selR = {4'(k), 4'(k)};
            #1;
            total++;
            if (a_rOut !== 32'h0) begin
                bad++;
                $display("FAIL clr_all r%0d got=%h want=0", k, a_rOut);
            end
        end
        a_clr = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (a_busy !== (a_left > 0)) begin
                bad++;
                $display("FAIL clr_held c%0d got=%b want=%b", c, a_busy, a_left > 0);
            end
        end
        drain();
    endtask

    task automatic test_write_during_clear();
        @(negedge clk);
        a_wen = 1'b1; a_selRd = 4'd9; a_rd = 16'h0055; a_clr = 1'b1;
        @(negedge clk);
        a_wen = 1'b0; a_clr = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) begin
                a_wen = 1'b1; a_selRd = 4'd3; a_rd = 16'h0007;
            end else begin
                a_wen = 1'b0;
            end
            a_selR = {4'd9, 4'd3};
            #1;
            total++;
            if (a_rOut[15:0] !== 16'h0) begin
                bad++;
                $display("FAIL wdc_r3 c%0d got=%h want=0", c, a_rOut[15:0]);
            end
            total++;
            if (a_rOut[31:16] !== ((c <= 9) ? 16'h0055 : 16'h0)) begin
                bad++;
                $display("FAIL wdc_r9 c%0d got=%h want=%h", c, a_rOut[31:16],
                         (c <= 9) ? 16'h0055 : 16'h0);
            end
            total++;
            if (a_busy !== 1'b1 || a_drop !== (c == 9)) begin
                bad++;
                $display("FAIL wdc_status c%0d got=%b%b want=1%b", c, a_busy, a_drop, c == 9);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (a_busy !== 1'b0 || a_drop !== 1'b0) begin
            bad++;
            $display("FAIL wdc_end got=%b%b want=00", a_busy, a_drop);
        end
    endtask

    task automatic test_multiport();
        logic [31:0] v7, v31;
        int n;
        v7  = 32'h7000_0000 | 32'($urandom_range(1, 16'hFFFF));
        v31 = 32'h3100_0000 | 32'($urandom_range(1, 16'hFFFF));
        @(negedge clk);
        b_wen = 1'b1; b_selRd = 5'd7; b_rd = v7;
        @(negedge clk);
        b_selRd = 5'd31; b_rd = v31;
        @(negedge clk);
        b_selRd = 5'd0; b_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        b_wen = 1'b0;
        b_selR = {5'd0, 5'd31, 5'd7, 5'd7};
        #1;
        total++;
        if (b_rOut !== {32'h0, v31, v7, v7}) begin
            bad++;
            $display("FAIL mp_read got=%h want=%h", b_rOut, {32'h0, v31, v7, v7});
        end
        for (int n2 = 0; n2 < 200; n2++) begin
            @(negedge clk);
            b_wen   = 1'($urandom);
            b_selRd = 5'($urandom);
            b_rd    = $urandom;
            b_selR  = 20'($urandom);
            b_clr   = ($urandom_range(0, 60) == 0);
            #1;
            for (int p = 0; p < 4; p++) begin
                total++;
                if (b_rOut[p*32 +: 32] !== expb(b_selR[p*5 +: 5])) begin
                    bad++;
                    $display("FAIL rand_b n%0d p%0d got=%h want=%h", n2, p,
                             b_rOut[p*32 +: 32], expb(b_selR[p*5 +: 5]));
                end
            end
            total++;
            if (b_busy !== (b_left > 0) || b_drop !== b_xdrop) begin
                bad++;
                $display("FAIL rand_b_status n%0d got=%b%b want=%b%b", n2,
                         b_busy, b_drop, b_left > 0, b_xdrop);
            end
        end
        drain();
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 80) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL mp_clr_len got=%0d want=32", n);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_wen = 1'b0; a_clr = 1'b0; a_selRd = '0; a_rd = '0; a_selR = '0;
        b_wen = 1'b0; b_clr = 1'b0; b_selRd = '0; b_rd = '0; b_selR = '0;
        reset_model();
        #2;
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_r0();
        test_back_to_back();
        test_soft_clear();
        test_write_during_clear();
        test_multiport();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
